// File: rtl/tdm_pkg.sv
// Shared types and helpers for the 1:4 TDM receive demultiplexer.
package tdm_pkg;

  localparam int unsigned NCH     = 4;
  localparam int unsigned SLOT_W  = 2;
  localparam int unsigned MaxCntW = 32;

  typedef enum logic [0:0] {HUNT, LOCKED} tdm_state_t;

  // Counters up to MaxCntW bits share this; callers zero-extend and truncate.
  function automatic logic [MaxCntW-1:0] sat_inc(input logic [MaxCntW-1:0] count,
                                                 input int unsigned        width);
    logic [MaxCntW-1:0] max_val;
    max_val = (width >= MaxCntW) ? '1 : ((MaxCntW'(1) << width) - MaxCntW'(1));
    return (count >= max_val) ? count : count + MaxCntW'(1);
  endfunction

endpackage

// File: rtl/tdm_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module tdm_sat_counter import tdm_pkg::*; #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = CNT_W'(sat_inc(MaxCntW'(count_q), CNT_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/tdm_demux4.sv
// 1:4 TDM demultiplexer: aligns on frame_sync, stages slots 0..2 and publishes
// the whole frame on the slot-3 beat so consumers never see a partial frame.
module tdm_demux4 import tdm_pkg::*; #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  output logic [NCH*WIDTH-1:0] ch_data,
  output logic                 frame_valid,
  output logic [NCH-1:0]       slot_strobe,
  output logic                 locked,
  output logic                 sync_err,
  output logic [CNT_W-1:0]     frame_count,
  output logic [CNT_W-1:0]     err_count
);

  tdm_state_t                     state_q, state_d;
  logic [SLOT_W-1:0]              slot_q, slot_d;
  logic [NCH-2:0][WIDTH-1:0]      stage_q, stage_d;
  logic [NCH*WIDTH-1:0]           ch_data_q, ch_data_d;
  logic                           frame_valid_q, frame_valid_d;
  logic [NCH-1:0]                 slot_strobe_q, slot_strobe_d;
  logic                           sync_err_q, sync_err_d;
  logic                           frame_inc, err_inc;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    stage_d       = stage_q;
    ch_data_d     = ch_data_q;
    frame_valid_d = 1'b0;
    slot_strobe_d = '0;
    sync_err_d    = 1'b0;
    frame_inc     = 1'b0;
    err_inc       = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            stage_d[0]    = din;
            slot_d        = SLOT_W'(1);
            slot_strobe_d = NCH'(1);
            state_d       = LOCKED;
          end
        end
        LOCKED: begin
          if (slot_q == '0 && !frame_sync) begin
            sync_err_d = 1'b1;
            err_inc    = 1'b1;
            slot_d     = '0;
            state_d    = HUNT;
          end else if (frame_sync) begin
            // Normal slot 0 or early resync: either way this beat starts a new frame.
            sync_err_d    = (slot_q != '0);
            err_inc       = (slot_q != '0);
            stage_d[0]    = din;
            slot_d        = SLOT_W'(1);
            slot_strobe_d = NCH'(1);
          end else if (slot_q == SLOT_W'(NCH - 1)) begin
            ch_data_d     = {din, stage_q[2], stage_q[1], stage_q[0]};
            frame_valid_d = 1'b1;
            frame_inc     = 1'b1;
            slot_d        = '0;
            slot_strobe_d = NCH'(1) << slot_q;
          end else begin
            if (slot_q == SLOT_W'(1)) stage_d[1] = din;
            else                      stage_d[2] = din;
            slot_d        = slot_q + SLOT_W'(1);
            slot_strobe_d = NCH'(1) << slot_q;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      slot_q        <= '0;
      stage_q       <= '0;
      ch_data_q     <= '0;
      frame_valid_q <= 1'b0;
      slot_strobe_q <= '0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      stage_q       <= stage_d;
      ch_data_q     <= ch_data_d;
      frame_valid_q <= frame_valid_d;
      slot_strobe_q <= slot_strobe_d;
      sync_err_q    <= sync_err_d;
    end
  end

  tdm_sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (frame_inc),
    .count (frame_count)
  );

  tdm_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (err_count)
  );

  assign ch_data     = ch_data_q;
  assign frame_valid = frame_valid_q;
  assign slot_strobe = slot_strobe_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios plus random streaming
// against a queue-based frame model; a CNT_W=2 instance exercises saturation.
module tb_tdm_demux4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        frame_sync = 1'b0;

  logic [31:0] ch_data;
  logic        frame_valid, locked, sync_err;
  logic [3:0]  slot_strobe;
  logic [15:0] frame_count, err_count;

  logic [31:0] s_ch_data;
  logic        s_frame_valid, s_locked, s_sync_err;
  logic [3:0]  s_slot_strobe;
  logic [1:0]  s_frame_count, s_err_count;

  int checks = 0;
  int fails  = 0;

  // Reference model: beats of the frame in progress, plus expected outputs.
  logic [7:0]  q[$];
  logic        exp_locked;
  logic [31:0] exp_ch;
  logic        exp_fv, exp_err;
  logic [3:0]  exp_strobe;
  int          n_frames, n_errs;

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .ch_data(ch_data), .frame_valid(frame_valid), .slot_strobe(slot_strobe),
    .locked(locked), .sync_err(sync_err), .frame_count(frame_count), .err_count(err_count)
  );

  tdm_demux4 #(.WIDTH(8), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .ch_data(s_ch_data), .frame_valid(s_frame_valid), .slot_strobe(s_slot_strobe),
    .locked(s_locked), .sync_err(s_sync_err), .frame_count(s_frame_count),
    .err_count(s_err_count)
  );

  function automatic int sat(input int n, input int max);
    return (n > max) ? max : n;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_locked = 1'b0;
    exp_ch     = '0;
    exp_fv     = 1'b0;
    exp_err    = 1'b0;
    exp_strobe = '0;
    n_frames   = 0;
    n_errs     = 0;
  endtask

  // Drive one cycle, advance the model on the edge, return 1 time unit later.
  task automatic step(input logic [7:0] d, input logic s, input logic v);
    din = d; frame_sync = s; din_valid = v;
    @(posedge clk);
    exp_fv = 1'b0; exp_err = 1'b0; exp_strobe = '0;
    if (v) begin
      if (s) begin
        if (exp_locked && q.size() != 0) begin exp_err = 1'b1; n_errs++; end
        q.delete();
        q.push_back(d);
        exp_locked = 1'b1;
        exp_strobe = 4'b0001;
      end else if (exp_locked) begin
        if (q.size() == 0) begin
          exp_err = 1'b1; n_errs++; exp_locked = 1'b0;
        end else begin
          exp_strobe = 4'(1 << q.size());
          q.push_back(d);
          if (q.size() == 4) begin
            exp_ch = {q[3], q[2], q[1], q[0]};
            exp_fv = 1'b1;
            n_frames++;
            q.delete();
          end
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    din_valid = 1'b0; frame_sync = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    checks++;
    if (ch_data !== 32'h0 || frame_valid !== 1'b0 || slot_strobe !== 4'h0 || locked !== 1'b0 ||
        sync_err !== 1'b0 || frame_count !== 16'h0 || err_count !== 16'h0) begin
      fails++;
      $display("FAIL reset_initial: ch=%h fv=%b st=%b lk=%b er=%b fc=%0d ec=%0d (want all 0)",
               ch_data, frame_valid, slot_strobe, locked, sync_err, frame_count, err_count);
    end
    @(posedge clk); #3 rst = 1'b0;
    step(8'h01, 1'b1, 1'b1); step(8'h02, 1'b0, 1'b1);
    step(8'h03, 1'b0, 1'b1); step(8'h04, 1'b0, 1'b1);
    step(8'h55, 1'b1, 1'b1); step(8'h66, 1'b0, 1'b1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (ch_data !== 32'h0 || frame_valid !== 1'b0 || slot_strobe !== 4'h0 || locked !== 1'b0 ||
        sync_err !== 1'b0 || frame_count !== 16'h0 || err_count !== 16'h0) begin
      fails++;
      $display("FAIL reset_async_midframe: ch=%h fv=%b st=%b lk=%b fc=%0d ec=%0d (want all 0)",
               ch_data, frame_valid, slot_strobe, locked, frame_count, err_count);
    end
    #2 rst = 1'b0;
    step(8'h11, 1'b1, 1'b1); step(8'h22, 1'b0, 1'b1);
    step(8'h33, 1'b0, 1'b1); step(8'h44, 1'b0, 1'b1);
    checks++;
    if (ch_data !== 32'h44332211 || frame_valid !== 1'b1 || frame_count !== 16'd1) begin
      fails++;
      $display("FAIL reset_next_frame: ch=%h fv=%b fc=%0d (want 44332211 1 1)",
               ch_data, frame_valid, frame_count);
    end
  endtask

  task automatic test_normal_lock();
    logic [7:0] beats[4];
    logic [3:0] want_st[4];
    beats   = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    want_st = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int k = 0; k < 4; k++) begin
      step(beats[k], k == 0, 1'b1);
      checks++;
      if (slot_strobe !== want_st[k] || slot_strobe !== exp_strobe) begin
        fails++;
        $display("FAIL lock_strobe%0d: got %b want %b", k, slot_strobe, want_st[k]);
      end
    end
    checks++;
    if (ch_data !== 32'hD4C3B2A1 || frame_valid !== 1'b1 || locked !== 1'b1 ||
        frame_count !== 16'(n_frames)) begin
      fails++;
      $display("FAIL lock_frame: ch=%h fv=%b lk=%b fc=%0d (want D4C3B2A1 1 1 %0d)",
               ch_data, frame_valid, locked, frame_count, n_frames);
    end
    step(8'h00, 1'b0, 1'b0);
    checks++;
    if (frame_valid !== 1'b0 || slot_strobe !== 4'h0 || ch_data !== 32'hD4C3B2A1) begin
      fails++;
      $display("FAIL lock_idle_hold: fv=%b st=%b ch=%h (want 0 0 D4C3B2A1)",
               frame_valid, slot_strobe, ch_data);
    end
  endtask

  task automatic test_hunt_gaps();
    int errs_seen = 0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(8'($urandom), 1'b0, 1'b1);
      if (sync_err) errs_seen++;
      checks++;
      if (locked !== 1'b0 || slot_strobe !== 4'h0) begin
        fails++;
        $display("FAIL hunt_discard%0d: lk=%b st=%b (want 0 0)", k, locked, slot_strobe);
      end
    end
    for (int k = 0; k < 4; k++) begin
      step(8'(k + 1), k == 0, 1'b1);
      if (sync_err) errs_seen++;
      for (int g = 0; g < 2; g++) begin
        step(8'hEE, 1'b1, 1'b0);
        if (sync_err) errs_seen++;
      end
    end
    checks++;
    if (ch_data !== 32'h04030201 || frame_count !== 16'd1 || errs_seen != 0 ||
        err_count !== 16'd0) begin
      fails++;
      $display("FAIL hunt_gaps_frame: ch=%h fc=%0d errs=%0d ec=%0d (want 04030201 1 0 0)",
               ch_data, frame_count, errs_seen, err_count);
    end
  endtask

  task automatic test_early_sync();
    int fv_seen = 0;
    logic [7:0] beats[6];
    logic       syncs[6];
    int         base_err;
    beats = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    syncs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    base_err = n_errs;
    for (int k = 0; k < 6; k++) begin
      step(beats[k], syncs[k], 1'b1);
      if (k < 5 && frame_valid) fv_seen++;
      if (k == 2) begin
        checks++;
        if (sync_err !== 1'b1 || frame_valid !== 1'b0 || slot_strobe !== 4'b0001 ||
            locked !== 1'b1) begin
          fails++;
          $display("FAIL early_sync_pulse: er=%b fv=%b st=%b lk=%b (want 1 0 0001 1)",
                   sync_err, frame_valid, slot_strobe, locked);
        end
      end
    end
    checks++;
    if (ch_data !== 32'h60504030 || frame_valid !== 1'b1 || fv_seen != 0 ||
        err_count !== 16'(base_err + 1) || n_errs != base_err + 1) begin
      fails++;
      $display("FAIL early_sync_frame: ch=%h fv=%b early_fv=%0d ec=%0d (want 60504030 1 0 %0d)",
               ch_data, frame_valid, fv_seen, err_count, base_err + 1);
    end
  endtask

  task automatic test_missing_sync();
    step(8'h77, 1'b0, 1'b1);
    checks++;
    if (sync_err !== 1'b1 || locked !== 1'b0 || ch_data !== 32'h60504030 ||
        err_count !== 16'(n_errs) || frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL missing_sync: er=%b lk=%b ch=%h ec=%0d fv=%b (want 1 0 60504030 %0d 0)",
               sync_err, locked, ch_data, err_count, frame_valid, n_errs);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 40; k++) begin
      step(8'($urandom), (k % 4) == 0, 1'b1);
      checks++;
      if (frame_valid !== ((k % 4) == 3) || frame_valid !== exp_fv ||
          (exp_fv && ch_data !== exp_ch)) begin
        fails++;
        $display("FAIL b2b_cycle%0d: fv=%b ch=%h want fv=%b ch=%h",
                 k, frame_valid, ch_data, exp_fv, exp_ch);
      end
    end
    checks++;
    if (frame_count !== 16'd10 || err_count !== 16'd0 || s_frame_count !== 2'd3) begin
      fails++;
      $display("FAIL b2b_counts: fc=%0d ec=%0d sfc=%0d (want 10 0 3)",
               frame_count, err_count, s_frame_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(8'(k), 1'b1, 1'b1);
      checks++;
      if (sync_err !== (k != 0) || s_err_count !== 2'(sat(n_errs, 3))) begin
        fails++;
        $display("FAIL sat_step%0d: er=%b sec=%0d want er=%b sec=%0d",
                 k, sync_err, s_err_count, k != 0, sat(n_errs, 3));
      end
    end
    checks++;
    if (s_err_count !== 2'd3 || err_count !== 16'd5) begin
      fails++;
      $display("FAIL sat_final: sec=%0d ec=%0d (want 3 5)", s_err_count, err_count);
    end
  endtask

  task automatic test_random();
    logic       v, s, want_sync;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      want_sync = (q.size() == 0);
      s = ($urandom_range(0, 9) == 0) ? !want_sync : want_sync;
      step(d, s, v);
      checks++;
      if (ch_data !== exp_ch || frame_valid !== exp_fv || slot_strobe !== exp_strobe ||
          sync_err !== exp_err || locked !== exp_locked ||
          frame_count !== 16'(n_frames) || err_count !== 16'(n_errs) ||
          s_frame_count !== 2'(sat(n_frames, 3)) || s_err_count !== 2'(sat(n_errs, 3)) ||
          (frame_valid && sync_err)) begin
        fails++;
        $display("FAIL random_cycle%0d: ch=%h fv=%b st=%b er=%b lk=%b fc=%0d ec=%0d sfc=%0d sec=%0d want ch=%h fv=%b st=%b er=%b lk=%b fc=%0d ec=%0d",
                 i, ch_data, frame_valid, slot_strobe, sync_err, locked, frame_count,
                 err_count, s_frame_count, s_err_count, exp_ch, exp_fv, exp_strobe,
                 exp_err, exp_locked, n_frames, n_errs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal_lock();
    test_hunt_gaps();
    test_early_sync();
    test_missing_sync();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side 1:4 time-division demultiplexer. It is the counterpart of the team's 4:1 mux trees used as a TDM serialiser.
- Takes one WIDTH-bit stream in which each frame is 4 consecutive valid beats, slot 0 marked by frame_sync.
- Reassembles each frame into four parallel channel words and publishes them atomically.
- Tracks sync loss and keeps error and frame statistics. Sits between the serial link and the per-channel consumers.

Parameters:
- WIDTH, 8, bits per channel word / per beat.
- CNT_W, 16, width of the saturating frame and error counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  serial data beat.
- din_valid  input  1  din carries a beat this cycle.
- frame_sync  input  1  qualifies the current beat as slot 0; ignored when din_valid=0.
- ch_data  output  4*WIDTH  reassembled frame; ch_data[WIDTH*k +: WIDTH] = slot k.
- frame_valid  output  1  one-cycle pulse: ch_data just updated with a complete frame.
- slot_strobe  output  4  one-hot pulse: slot k was captured on the previous edge.
- locked  output  1  1 in state LOCKED.
- sync_err  output  1  one-cycle pulse on a framing violation.
- frame_count  output  CNT_W  completed frames, saturating at all-ones.
- err_count  output  CNT_W  sync_err events, saturating at all-ones.

Behaviour:
- Reset (async, asserts immediately): ch_data=0, frame_valid=0, slot_strobe=0, locked=0, sync_err=0, both counters=0, slot=0, staging=0, state=HUNT. Release is synchronous to clk.
- States: HUNT, LOCKED. Internal 2-bit slot counter and three WIDTH-bit staging registers for slots 0..2.
- Beat = din_valid=1 at a rising edge. Cycles with din_valid=0 change nothing except clearing the pulse outputs. Gaps between beats are allowed anywhere in a frame.
- HUNT:
  - A beat with frame_sync=0 is discarded; no error.
  - A beat with frame_sync=1 goes to stage0, sets slot=1, slot_strobe=0001, and moves to LOCKED.
- LOCKED, beat with slot=0:
  - frame_sync=1: normal; capture to stage0, slot=1.
  - frame_sync=0: lost sync. Pulse sync_err, err_count+1, no capture, go to HUNT, slot=0.
- LOCKED, beat with slot=1 or 2:
  - frame_sync=0: capture to stage[slot], slot+1.
  - frame_sync=1: early sync (resync). Pulse sync_err, err_count+1, discard the partial frame, capture the beat as slot 0, slot=1, stay LOCKED. No frame_valid.
- LOCKED, beat with slot=3:
  - frame_sync=0: on the same edge, ch_data <= {din, stage2, stage1, stage0}, frame_valid=1, frame_count+1, slot wraps to 0.
  - frame_sync=1: treated as early sync, per the rule above.
- Latency: ch_data and frame_valid change one edge after the slot-3 beat is sampled, i.e. visible the cycle after. ch_data holds its value until the next complete frame; partial frames never reach ch_data.
- slot_strobe[k] pulses for one cycle after every slot-k capture, including a resync capture (bit 0).
- sync_err and frame_valid are never asserted in the same cycle.
- Counters saturate; they never wrap.
- Back-to-back frames with din_valid held high sustain 1 frame per 4 cycles with no bubble.

Decomposition:
- Package tdm_pkg holds:
  - NCH=4 and SLOT_W=2.
  - typedef enum {HUNT, LOCKED} tdm_state_t.
  - A function sat_inc(count) used by both counters.
- One sub-module is natural: tdm_sat_counter (CNT_W parameter; clk, rst, inc, count), instantiated twice.
- The slot counter, staging registers and FSM stay in tdm_demux4.

Test Plan:
- Reset mid-frame: after 2 beats of a frame, assert rst asynchronously between edges. All outputs are 0 immediately and state is HUNT; next frame 11,22,33,44 is reassembled correctly.
- Normal lock (WIDTH=8): beats 0xA1(sync),0xB2,0xC3,0xD4 -> one cycle after 0xD4, ch_data=0xD4C3B2A1, frame_valid pulse, frame_count=1, locked=1. slot_strobe pulses 0001,0010,0100,1000.
- Hunt discard plus idle gaps: 3 beats without sync, then a sync frame 01,02,03,04 with din_valid=0 gaps between beats -> no sync_err; ch_data=0x04030201; frame_count=1.
- Early sync: 0x10(sync),0x20, then 0x30(sync),0x40,0x50,0x60 -> one sync_err, err_count=1. Resulting ch_data=0x60504030; the earlier partial frame is never published.
- Missing sync after complete frame: frame completes, next beat has frame_sync=0 -> sync_err, locked=0, err_count+1, ch_data unchanged.
- Continuous streaming and saturation: 10 back-to-back frames -> frame_valid every 4th cycle, frame_count=10. With CNT_W=2 forced, 5 errors -> err_count holds at 3.
